// File: rtl/pipe_run_ctrl.sv
// Run controller for the five-stage Y86 pipeline: start-up flush/PC load,
// step and breakpoint pausing, watchdog, and latched final status.
module pipe_run_ctrl #(
    parameter int          CNT_W      = 32,
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          MAX_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop_req,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             bp_en,
    input  logic [63:0]      bp_pc,
    input  logic [63:0]      f_pc,
    input  logic [3:0]       W_stat,
    input  logic             W_valid,
    output logic             pipe_en,
    output logic             pipe_flush,
    output logic             pc_load,
    output logic [63:0]      pc_init,
    output logic [2:0]       state,
    output logic [3:0]       run_stat,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] WD_LIM  = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       ST_AOK  = 4'd1;
    localparam logic [3:0]       ST_TMO  = 4'd5;

    state_t           state_q;
    logic             pipe_flush_q;
    logic             pc_load_q;
    logic [3:0]       run_stat_q;
    logic             done_q;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] retired_cnt_q;
    logic             resume_skip_q;
    logic             single_q;

    logic term;
    logic bp_hit;
    logic wd;
    logic adv;

    assign term   = (W_stat == 4'd2) || (W_stat == 4'd3) || (W_stat == 4'd4);
    assign bp_hit = bp_en && (f_pc == bp_pc) && !resume_skip_q;
    assign wd     = (MAX_CYCLES != 0) && (cycle_cnt_q >= WD_LIM);
    assign adv    = (state_q == RUN) && !term && !stop_req && !wd && !bp_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pipe_flush_q  <= 1'b0;
            pc_load_q     <= 1'b0;
            run_stat_q    <= 4'd0;
            done_q        <= 1'b0;
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
            resume_skip_q <= 1'b0;
            single_q      <= 1'b0;
        end else begin
            pipe_flush_q <= 1'b0;
            pc_load_q    <= 1'b0;

            if (adv && cycle_cnt_q != CNT_MAX)
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            if (adv && W_valid && W_stat == ST_AOK && retired_cnt_q != CNT_MAX)
                retired_cnt_q <= retired_cnt_q + 1'b1;

            unique case (state_q)
                IDLE, DONE: begin
                    // Counters and status read as zero for the whole INIT cycle.
                    if (start) begin
                        state_q       <= INIT;
                        pipe_flush_q  <= 1'b1;
                        pc_load_q     <= 1'b1;
                        run_stat_q    <= 4'd0;
                        done_q        <= 1'b0;
                        cycle_cnt_q   <= '0;
                        retired_cnt_q <= '0;
                    end
                end
                INIT: begin
                    state_q       <= RUN;
                    resume_skip_q <= 1'b0;
                    single_q      <= 1'b0;
                end
                RUN: begin
                    resume_skip_q <= 1'b0;
                    single_q      <= 1'b0;
                    if (term) begin
                        state_q    <= DONE;
                        run_stat_q <= W_stat;
                        done_q     <= 1'b1;
                    end else if (stop_req) begin
                        state_q    <= DONE;
                        run_stat_q <= ST_AOK;
                        done_q     <= 1'b1;
                    end else if (wd) begin
                        state_q    <= DONE;
                        run_stat_q <= ST_TMO;
                        done_q     <= 1'b1;
                    end else if (bp_hit || step_mode || single_q) begin
                        state_q <= PAUSE;
                    end
                end
                PAUSE: begin
                    // A step_req resume runs exactly one cycle whatever step_mode says.
                    if (stop_req) begin
                        state_q    <= DONE;
                        run_stat_q <= ST_AOK;
                        done_q     <= 1'b1;
                    end else if (start) begin
                        state_q       <= RUN;
                        resume_skip_q <= 1'b1;
                        single_q      <= 1'b0;
                    end else if (step_req) begin
                        state_q       <= RUN;
                        resume_skip_q <= 1'b1;
                        single_q      <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pipe_en     = adv;
    assign pipe_flush  = pipe_flush_q;
    assign pc_load     = pc_load_q;
    assign pc_init     = RESET_PC;
    assign state       = state_q;
    assign run_stat    = run_stat_q;
    assign done        = done_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign retired_cnt = retired_cnt_q;

endmodule
